// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared definitions for the multi-cycle core controller.
//   - state_t      : controller FSM state encoding (also driven on core_ctrl.state)
//   - opcode consts: RV32I major opcodes recognised by the decoder
//   - CLS_*        : bit positions of the one-hot instruction class vector
//   - PC_SEL_*/WB_SEL_* : encodings of the pc_sel and wb_sel outputs
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6
    } state_t;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] R           = 7'h33;
    localparam logic [6:0] I_TYPE      = 7'h13;
    localparam logic [6:0] I_TYPE_LOAD = 7'h03;
    localparam logic [6:0] S_TYPE      = 7'h23;
    localparam logic [6:0] B_TYPE      = 7'h63;
    localparam logic [6:0] J_JAL       = 7'h6F;
    localparam logic [6:0] I_JALR      = 7'h67;
    localparam logic [6:0] U_AUIPC     = 7'h17;
    localparam logic [6:0] U_LUI       = 7'h37;
    localparam logic [6:0] SYSTEM      = 7'h73;

    // One-hot class vector bit positions
    localparam int unsigned CLS_R       = 0;
    localparam int unsigned CLS_IALU    = 1;
    localparam int unsigned CLS_LOAD    = 2;
    localparam int unsigned CLS_STORE   = 3;
    localparam int unsigned CLS_BRANCH  = 4;
    localparam int unsigned CLS_JAL     = 5;
    localparam int unsigned CLS_JALR    = 6;
    localparam int unsigned CLS_AUIPC   = 7;
    localparam int unsigned CLS_LUI     = 8;
    localparam int unsigned CLS_SYSTEM  = 9;
    localparam int unsigned NUM_CLASSES = 10;

    // pc_sel encodings
    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_PC_IMM = 2'b01;
    localparam logic [1:0] PC_SEL_RS1    = 2'b10;

    // wb_sel encodings
    localparam logic [1:0] WB_SEL_ALU    = 2'b00;
    localparam logic [1:0] WB_SEL_MEM    = 2'b01;
    localparam logic [1:0] WB_SEL_PC4    = 2'b10;
    localparam logic [1:0] WB_SEL_IMM    = 2'b11;

endpackage

// File: rtl/core_ctrl_opclass.sv
// ctrl_opclass: combinational opcode classifier.
// Ports:
//   opcode   in  [6:0]              latched major opcode
//   class_oh out [NUM_CLASSES-1:0]  one-hot instruction class (all zero when illegal)
//   legal    out                    opcode is one of the supported major opcodes
module ctrl_opclass
    import core_ctrl_pkg::*;
(
    input  logic [6:0]             opcode,
    output logic [NUM_CLASSES-1:0] class_oh,
    output logic                   legal
);

    always_comb begin
        class_oh = '0;
        legal    = 1'b1;
        case (opcode)
            R:           class_oh[CLS_R]      = 1'b1;
            I_TYPE:      class_oh[CLS_IALU]   = 1'b1;
            I_TYPE_LOAD: class_oh[CLS_LOAD]   = 1'b1;
            S_TYPE:      class_oh[CLS_STORE]  = 1'b1;
            B_TYPE:      class_oh[CLS_BRANCH] = 1'b1;
            J_JAL:       class_oh[CLS_JAL]    = 1'b1;
            I_JALR:      class_oh[CLS_JALR]   = 1'b1;
            U_AUIPC:     class_oh[CLS_AUIPC]  = 1'b1;
            U_LUI:       class_oh[CLS_LUI]    = 1'b1;
            SYSTEM:      class_oh[CLS_SYSTEM] = 1'b1;
            default:     legal                = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle control FSM for a simple RV32I core.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 leave IDLE and begin fetching
//   instruction[31:0]     fetched word, valid while imem_ready=1 in FETCH
//   imem_req / imem_ready instruction fetch handshake
//   dmem_req / dmem_we / dmem_ready  data handshake (dmem_we=1 for store)
//   branch_taken          ALU compare result, used in EXECUTE
//   ir_load               latch instruction into IR
//   pc_write, pc_sel[1:0] PC update strobe and source (00 pc+4, 01 pc+imm, 10 rs1+imm)
//   rf_we, wb_sel[1:0]    register write strobe and source (00 ALU, 01 mem, 10 pc+4, 11 imm)
//   alu_src_imm           ALU operand B from immediate
//   state[2:0]            current FSM state
//   halted, illegal       HALT reached / halted on an unsupported opcode
//   instret[31:0]         retired-instruction count (wraps)
module core_ctrl
    import core_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instruction,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_imm,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t                   state_q;
    state_t                   state_d;
    logic [6:0]               opcode_q;
    logic [4:0]               rd_q;
    logic [31:0]              instret_q;
    logic                     illegal_q;
    logic [NUM_CLASSES-1:0]   cls;
    logic                     op_legal;
    logic                     retire;

    // Only opcode and rd are needed by the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[31:12];

    ctrl_opclass u_opclass (
        .opcode   (opcode_q),
        .class_oh (cls),
        .legal    (op_legal)
    );

    logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic is_ialu, is_r, is_system, needs_imm, goes_to_wb;

    assign is_r      = cls[CLS_R];
    assign is_ialu   = cls[CLS_IALU];
    assign is_load   = cls[CLS_LOAD];
    assign is_store  = cls[CLS_STORE];
    assign is_branch = cls[CLS_BRANCH];
    assign is_jal    = cls[CLS_JAL];
    assign is_jalr   = cls[CLS_JALR];
    assign is_auipc  = cls[CLS_AUIPC];
    assign is_lui    = cls[CLS_LUI];
    assign is_system = cls[CLS_SYSTEM];

    assign needs_imm  = is_ialu | is_load | is_store | is_jalr | is_auipc | is_lui;
    assign goes_to_wb = is_r | is_ialu | is_jal | is_jalr | is_auipc | is_lui;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!op_legal || is_system) begin
                    state_d = HALT;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (is_load || is_store) begin
                    state_d = MEM;
                end else if (is_branch) begin
                    state_d = FETCH;
                end else if (goes_to_wb) begin
                    state_d = WB;
                end else begin
                    state_d = HALT;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    state_d = is_store ? FETCH : WB;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_load     = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = PC_SEL_PLUS4;
        rf_we       = 1'b0;
        wb_sel      = WB_SEL_ALU;
        alu_src_imm = 1'b0;
        halted      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            EXECUTE: begin
                alu_src_imm = needs_imm;
                if (is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken ? PC_SEL_PC_IMM : PC_SEL_PLUS4;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                // A store retires on its data handshake; a load retires in WB.
                pc_write = is_store & dmem_ready;
            end
            WB: begin
                rf_we    = (rd_q != 5'd0);
                pc_write = 1'b1;
                if (is_load) begin
                    wb_sel = WB_SEL_MEM;
                end else if (is_jal || is_jalr) begin
                    wb_sel = WB_SEL_PC4;
                end else if (is_lui) begin
                    wb_sel = WB_SEL_IMM;
                end
                if (is_jal) begin
                    pc_sel = PC_SEL_PC_IMM;
                end else if (is_jalr) begin
                    pc_sel = PC_SEL_RS1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    // Every retiring instruction updates the PC exactly once, so the PC
    // write strobe doubles as the retire event.
    assign retire = pc_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            rd_q      <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (ir_load) begin
                opcode_q <= instruction[6:0];
                rd_q     <= instruction[11:7];
            end
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
            if (state_q == DECODE && !op_legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed, table-driven bench for core_ctrl.
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] instruction;
    logic        imem_req, imem_ready;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        branch_taken;
    logic        ir_load, pc_write, rf_we, alu_src_imm;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic        halted, illegal;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instret;

    always #5 clk = ~clk;

    core_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .instruction  (instruction),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_src_imm  (alu_src_imm),
        .state        (state),
        .halted       (halted),
        .illegal      (illegal),
        .instret      (instret)
    );

    typedef struct {
        logic [31:0] instr;
        logic        bt;
        int unsigned dwait;
        int unsigned cycles;
        logic [11:0] seq;     // last four states visited, oldest in the MSBs
        logic        alu_imm;
        logic [1:0]  pc_sel;
        logic [1:0]  wb_sel;
        logic        rf_we;
        int unsigned dreq;
        logic        we;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] strobes();
        return {imem_req, dmem_req, dmem_we, ir_load, pc_write, rf_we,
                alu_src_imm, pc_sel, wb_sel};
    endfunction

    int unsigned cyc, mem_n, dreq_n, pcw_n;
    logic        alu_s, we_s, rfwe_s, done;
    logic [1:0]  pcs_s, wbs_s;
    logic [11:0] seq;

    initial begin
        //            instr         bt    dw cyc seq       imm   pcs    wbs    rfwe dreq we
        vecs[0]  = '{32'h00500093, 1'b0, 0, 4, 12'h29D, 1'b1, 2'b00, 2'b00, 1'b1, 0, 1'b0}; // addi x1,x0,5
        vecs[1]  = '{32'h0000A103, 1'b0, 3, 8, 12'h925, 1'b1, 2'b00, 2'b01, 1'b1, 4, 1'b0}; // lw, ready +3
        vecs[2]  = '{32'h0000A103, 1'b0, 0, 5, 12'h4E5, 1'b1, 2'b00, 2'b01, 1'b1, 1, 1'b0}; // lw, zero wait
        vecs[3]  = '{32'h00000463, 1'b1, 0, 3, 12'h053, 1'b0, 2'b01, 2'b00, 1'b0, 0, 1'b0}; // beq taken
        vecs[4]  = '{32'h00000463, 1'b0, 0, 3, 12'h053, 1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b0}; // beq not taken
        vecs[5]  = '{32'h00000013, 1'b0, 0, 4, 12'h29D, 1'b1, 2'b00, 2'b00, 1'b0, 0, 1'b0}; // addi x0 (nop)
        vecs[6]  = '{32'h0020A223, 1'b0, 0, 4, 12'h29C, 1'b1, 2'b00, 2'b00, 1'b0, 1, 1'b1}; // sw, zero wait
        vecs[7]  = '{32'h0020A223, 1'b0, 2, 6, 12'h724, 1'b1, 2'b00, 2'b00, 1'b0, 3, 1'b1}; // sw, ready +2
        vecs[8]  = '{32'h000000EF, 1'b0, 0, 4, 12'h29D, 1'b0, 2'b01, 2'b10, 1'b1, 0, 1'b0}; // jal x1
        vecs[9]  = '{32'h000280E7, 1'b0, 0, 4, 12'h29D, 1'b1, 2'b10, 2'b10, 1'b1, 0, 1'b0}; // jalr x1,0(x5)
        vecs[10] = '{32'h123451B7, 1'b0, 0, 4, 12'h29D, 1'b1, 2'b00, 2'b11, 1'b1, 0, 1'b0}; // lui x3
        vecs[11] = '{32'h00001217, 1'b0, 0, 4, 12'h29D, 1'b1, 2'b00, 2'b00, 1'b1, 0, 1'b0}; // auipc x4
        vecs[12] = '{32'h002082B3, 1'b0, 0, 4, 12'h29D, 1'b0, 2'b00, 2'b00, 1'b1, 0, 1'b0}; // add x5,x1,x2

        // Reset with start held high; ready inputs high must be ignored.
        rst_n = 1'b0; start = 1'b1; instruction = '0;
        imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b0;
        exp_instret = '0;
        step();
        step();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_strobes", {21'd0, strobes()}, 32'd0);
        check("rst_flags", {30'd0, halted, illegal}, 32'd0);
        check("rst_instret", instret, 32'd0);

        // First cycle after release is IDLE; stray readies do nothing.
        rst_n = 1'b1; start = 1'b0;
        step();
        check("idle_ignores_ready", {29'd0, state}, 32'd0);
        check("idle_strobes", {21'd0, strobes()}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_to_fetch", {29'd0, state}, 32'd1);

        // Instruction memory stalls for two cycles.
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        check("fetch_wait_req", {31'd0, imem_req}, 32'd1);
        check("fetch_wait_irload", {31'd0, ir_load}, 32'd0);
        step();
        check("fetch_wait_state1", {29'd0, state}, 32'd1);
        check("fetch_wait_req1", {31'd0, imem_req}, 32'd1);
        step();
        check("fetch_wait_state2", {29'd0, state}, 32'd1);

        // Table: each entry starts and should end in FETCH.
        for (int i = 0; i < NV; i++) begin
            cyc = 0; mem_n = 0; dreq_n = 0; pcw_n = 0;
            alu_s = 1'b0; we_s = 1'b0; rfwe_s = 1'b0; done = 1'b0;
            pcs_s = 2'b00; wbs_s = 2'b00; seq = '0;
            for (int k = 0; k < 30 && !done; k++) begin
                instruction  = vecs[i].instr;
                imem_ready   = 1'b1;
                branch_taken = vecs[i].bt;
                dmem_ready   = (state == 3'd4) && (mem_n >= vecs[i].dwait);
                #1;
                seq = {seq[8:0], state};
                cyc++;
                if (state == 3'd3) alu_s = alu_src_imm;
                if (state == 3'd5) wbs_s = wb_sel;
                if (state == 3'd4) mem_n++;
                if (dmem_req) dreq_n++;
                if (dmem_we) we_s = 1'b1;
                if (rf_we) rfwe_s = 1'b1;
                if (pc_write) begin
                    pcw_n++;
                    pcs_s = pc_sel;
                end
                @(posedge clk);
                #1;
                if (state == 3'd1 || state == 3'd6) done = 1'b1;
            end
            exp_instret = exp_instret + 32'd1;
            check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d_end_state", i), {29'd0, state}, 32'd1);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
            check($sformatf("v%0d_states", i), {20'd0, seq}, {20'd0, vecs[i].seq});
            check($sformatf("v%0d_alu_imm", i), {31'd0, alu_s}, {31'd0, vecs[i].alu_imm});
            check($sformatf("v%0d_pc_sel", i), {30'd0, pcs_s}, {30'd0, vecs[i].pc_sel});
            check($sformatf("v%0d_wb_sel", i), {30'd0, wbs_s}, {30'd0, vecs[i].wb_sel});
            check($sformatf("v%0d_rf_we", i), {31'd0, rfwe_s}, {31'd0, vecs[i].rf_we});
            check($sformatf("v%0d_dmem_req_cycles", i), dreq_n, vecs[i].dreq);
            check($sformatf("v%0d_dmem_we", i), {31'd0, we_s}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_pc_write_count", i), pcw_n, 32'd1);
            check($sformatf("v%0d_instret", i), instret, exp_instret);
        end

        // Reset in the middle of a data handshake.
        instruction = 32'h0000A103; imem_ready = 1'b1; dmem_ready = 1'b0;
        step();
        step();
        step();
        check("mid_mem_state", {29'd0, state}, 32'd4);
        check("mid_mem_req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_instret = '0;
        check("mid_mem_rst_state", {29'd0, state}, 32'd0);
        check("mid_mem_rst_strobes", {21'd0, strobes()}, 32'd0);
        check("mid_mem_rst_instret", instret, exp_instret);

        // SYSTEM opcode halts cleanly.
        start = 1'b1;
        step();
        start = 1'b0;
        instruction = 32'h00000073;
        step();
        step();
        check("ecall_state", {29'd0, state}, 32'd6);
        check("ecall_flags", {30'd0, halted, illegal}, 32'b10);
        check("ecall_instret", instret, 32'd0);

        // Unsupported opcode halts with illegal; HALT ignores start.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst2_flags", {30'd0, halted, illegal}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        instruction = 32'hFFFFFFFF;
        step();
        step();
        check("illegal_state", {29'd0, state}, 32'd6);
        check("illegal_flags", {30'd0, halted, illegal}, 32'b11);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("halt_absorbing", {29'd0, state}, 32'd6);
        check("halt_flags_hold", {30'd0, halted, illegal}, 32'b11);
        check("halt_strobes", {21'd0, strobes()}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  leave IDLE and begin fetching.
REQ-004 SHALL have port: instruction  input  32  fetched word, valid when imem_ready=1.
REQ-005 SHALL have ports: imem_req output 1 and imem_ready input 1, the fetch handshake.
REQ-006 SHALL have ports: dmem_req output 1, dmem_we output 1 (1=store) and dmem_ready input 1, the data handshake.
REQ-007 SHALL have port: branch_taken  input  1  ALU compare result, sampled in EXECUTE.
REQ-008 SHALL have outputs: ir_load 1 (latch instruction), pc_write 1, pc_sel 2 (00 pc+4, 01 pc+imm, 10 rs1+imm), rf_we 1, wb_sel 2 (00 ALU, 01 mem, 10 pc+4, 11 imm), alu_src_imm 1.
REQ-009 SHALL have outputs: state 3 (current FSM state), halted 1, illegal 1, instret 32 (retired-instruction count).

Function
REQ-010 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
REQ-011 IDLE: all outputs 0; start=1 -> FETCH next cycle.
REQ-012 FETCH: imem_req=1 held until imem_ready=1; in the ready cycle ir_load=1 and next state is DECODE.
REQ-013 DECODE: classify the latched opcode [6:0]; an unsupported opcode -> HALT with illegal=1; opcode 7'h73 (SYSTEM) -> HALT with illegal=0; otherwise -> EXECUTE.
REQ-014 EXECUTE: alu_src_imm=1 for I-type ALU, load, store, JALR, AUIPC and LUI; 0 otherwise.
REQ-015 From EXECUTE, load/store -> MEM; branch -> FETCH; all other classes -> WB.
REQ-016 Branch in EXECUTE: pc_write=1 and instret increments; pc_sel=01 if branch_taken else 00.
REQ-017 MEM: dmem_req=1 held until dmem_ready=1; dmem_we=1 for store, 0 for load.
REQ-018 On dmem_ready in MEM: a load goes to WB; a store asserts pc_write (pc_sel=00), increments instret and goes to FETCH.
REQ-019 WB lasts one cycle: rf_we=1 unless rd (instruction[11:7]) is 0; pc_write=1; instret increments; next state FETCH.
REQ-020 WB selects: wb_sel=01 for load, 10 for JAL/JALR, 11 for LUI, 00 otherwise; pc_sel=01 for JAL, 10 for JALR, 00 otherwise.
REQ-021 Minimum latency with zero-wait memories: branch 3 cycles, ALU/jump/LUI/AUIPC/store 4 cycles, load 5 cycles.
REQ-022 imem_req or dmem_req, once asserted, SHALL stay high until the matching ready is seen; a ready arriving outside its request state is ignored.
REQ-023 instret SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 HALT is absorbing until reset: halted=1, illegal holds its value, all strobes 0, and start is ignored.
REQ-025 All strobe and select outputs SHALL be Moore-decoded from state and latched opcode; only ir_load, pc_write on store, and the state advance depend on the ready inputs.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, clear instret, illegal, halted and the opcode/rd latch, and drive all outputs to 0, including mid-handshake.
REQ-027 The first cycle after reset release SHALL be IDLE regardless of start.

Structure
REQ-028 The state encoding and the opcode constants (R, I_TYPE, I_TYPE_LOAD, S_TYPE, B_TYPE, J_JAL, I_JALR, U_AUIPC, U_LUI, SYSTEM) SHALL live in the shared defines package already used by the decoder.
REQ-029 The opcode-to-class decode SHALL be one combinational sub-module, ctrl_opclass, with a 7-bit input and a one-hot class plus legal output.

Verification
REQ-030 addi x1,x0,5 (32'h00500093), zero-wait memories -> states 1,2,3,5,1; rf_we=1 and wb_sel=00 in WB; instret=1.
REQ-031 lw x2,0(x1) with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; then WB with wb_sel=01 and rf_we=1.
REQ-032 beq taken (branch_taken=1) -> pc_write=1 and pc_sel=01 in EXECUTE; next state FETCH; rf_we never asserted.
REQ-033 addi x0,x0,0 (32'h00000013) -> rf_we=0 in WB; instret still increments.
REQ-034 instruction 32'hFFFFFFFF -> HALT with illegal=1 and halted=1; a later start pulse causes no state change.
REQ-035 rst_n=0 during MEM while dmem_req=1 -> next cycle IDLE, all outputs 0, instret=0.
